// File: rtl/grid_pkg.sv
// Shared constants, state encoding and width helpers for the grid loader.
package grid_pkg;

  localparam int GRID_WIDTH = 16;
  localparam int GRID_DEPTH = 16;

  localparam logic [7:0] CH_PAPER = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic {LOAD, HOLD} state_t;

  function automatic int col_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int row_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int cnt_w(input int width, input int depth);
    return $clog2(width * depth + 1);
  endfunction

  function automatic int idx_w(input int width, input int depth);
    return (width * depth > 1) ? $clog2(width * depth) : 1;
  endfunction

endpackage

// File: rtl/grid_loader_if.sv
// Byte-stream input and frame output handshakes of the grid loader.
interface grid_loader_if
  import grid_pkg::*;
#(
  parameter int WIDTH = GRID_WIDTH,
  parameter int DEPTH = GRID_DEPTH
);

  logic                            in_valid;
  logic                            in_ready;
  logic [7:0]                      in_data;
  logic                            grid_valid;
  logic                            grid_ready;
  logic [WIDTH*DEPTH-1:0]          grid_out;
  logic [row_w(DEPTH)-1:0]         rows_loaded;
  logic [cnt_w(WIDTH, DEPTH)-1:0]  paper_count;
  logic                            fmt_err;

  modport master (
    output in_valid, in_data, grid_ready,
    input  in_ready, grid_valid, grid_out, rows_loaded, paper_count, fmt_err
  );

  modport slave (
    input  in_valid, in_data, grid_ready,
    output in_ready, grid_valid, grid_out, rows_loaded, paper_count, fmt_err
  );

endinterface

// File: rtl/grid_char_decode.sv
// Combinational ASCII byte classifier for the grid loader.
module grid_char_decode
  import grid_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_paper,
  output logic       is_empty,
  output logic       is_lf,
  output logic       is_cr,
  output logic       is_bad
);

  assign is_paper = (data == CH_PAPER);
  assign is_empty = (data == CH_EMPTY);
  assign is_lf    = (data == CH_LF);
  assign is_cr    = (data == CH_CR);
  assign is_bad   = !(is_paper || is_empty || is_lf || is_cr);

endmodule

// File: rtl/grid_loader.sv
// Assembles an ASCII grid stream into a WIDTH x DEPTH occupancy bitmap.
// Optional ragged-row detection: define GRID_LOADER_RAGGED_CHECK_EN.
module grid_loader
  import grid_pkg::*;
#(
  parameter int WIDTH = GRID_WIDTH,
  parameter int DEPTH = GRID_DEPTH
) (
  input logic clk,
  input logic rst,
  grid_loader_if.slave bus
);

  localparam int COL_W = col_w(WIDTH);
  localparam int ROW_W = row_w(DEPTH);
  localparam int CNT_W = cnt_w(WIDTH, DEPTH);
  localparam int IDX_W = idx_w(WIDTH, DEPTH);

  state_t                 state;
  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic [WIDTH*DEPTH-1:0] grid;
  logic [CNT_W-1:0]       papers;
  logic [ROW_W-1:0]       rows_q;
  logic                   err;
  logic                   in_ready_q;
  logic                   grid_valid_q;

  logic is_paper, is_empty, is_lf, is_cr, is_bad;
  logic accept, col_full, ragged;
  logic [IDX_W-1:0] bit_idx;

  grid_char_decode u_decode (
    .data     (bus.in_data),
    .is_paper (is_paper),
    .is_empty (is_empty),
    .is_lf    (is_lf),
    .is_cr    (is_cr),
    .is_bad   (is_bad)
  );

  assign accept   = bus.in_valid && in_ready_q;
  assign col_full = (col == COL_W'(WIDTH));
  assign bit_idx  = IDX_W'(row) * IDX_W'(WIDTH) + IDX_W'(col);

`ifdef GRID_LOADER_RAGGED_CHECK_EN
  logic [COL_W-1:0] first_len;
  assign ragged = (row != '0) && (col != first_len);
`else
  assign ragged = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD;
      col          <= '0;
      row          <= '0;
      grid         <= '0;
      papers       <= '0;
      rows_q       <= '0;
      err          <= 1'b0;
      in_ready_q   <= 1'b1;
      grid_valid_q <= 1'b0;
`ifdef GRID_LOADER_RAGGED_CHECK_EN
      first_len    <= '0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (is_paper) begin
              if (col_full) begin
                err <= 1'b1;
              end else begin
                grid[bit_idx] <= 1'b1;
                col           <= col + COL_W'(1);
                papers        <= papers + CNT_W'(1);
              end
            end else if (is_lf) begin
              if (col != '0) begin
                row <= row + ROW_W'(1);
                col <= '0;
                if (ragged) err <= 1'b1;
`ifdef GRID_LOADER_RAGGED_CHECK_EN
                if (row == '0) first_len <= col;
`endif
                if (row == ROW_W'(DEPTH - 1)) begin
                  state        <= HOLD;
                  in_ready_q   <= 1'b0;
                  grid_valid_q <= 1'b1;
                  rows_q       <= ROW_W'(DEPTH);
                end
              end else if (row != '0) begin
                state        <= HOLD;
                in_ready_q   <= 1'b0;
                grid_valid_q <= 1'b1;
                rows_q       <= row;
              end
            end else if (!is_cr) begin
              // '.' and illegal bytes both occupy a column; past WIDTH they are dropped
              if (is_bad || (col_full && is_empty)) err <= 1'b1;
              if (!col_full) col <= col + COL_W'(1);
            end
          end
        end
        HOLD: begin
          if (bus.grid_ready) begin
            state        <= LOAD;
            col          <= '0;
            row          <= '0;
            grid         <= '0;
            papers       <= '0;
            rows_q       <= '0;
            err          <= 1'b0;
            in_ready_q   <= 1'b1;
            grid_valid_q <= 1'b0;
`ifdef GRID_LOADER_RAGGED_CHECK_EN
            first_len    <= '0;
`endif
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.grid_valid  = grid_valid_q;
  assign bus.grid_out    = grid;
  assign bus.rows_loaded = rows_q;
  assign bus.paper_count = papers;
  assign bus.fmt_err     = err;

endmodule

// File: tb/tb_grid_loader.sv
// Self-checking bench for grid_loader against a line-oriented frame model.
// Honours GRID_LOADER_RAGGED_CHECK_EN in the model when defined.
module tb_grid_loader;
  import grid_pkg::*;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int GW = W * D;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  grid_loader_if #(.WIDTH(W), .DEPTH(D)) bus ();
  grid_loader #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [GW-1:0] got, input logic [GW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] row_of(input logic [GW-1:0] g, input int i);
    return g[i*W +: W];
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Splits the stream into lines and applies the frame rules line by line.
  function automatic void model(input bq_t q, output logic [GW-1:0] g, output int rows,
                                output int papers, output logic err);
    bq_t line;
    int  first_len;
    int  len;
    g = '0; rows = 0; papers = 0; err = 1'b0; first_len = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] == CH_CR) continue;
      if (q[i] != CH_LF) begin
        line.push_back(q[i]);
        continue;
      end
      if (line.size() == 0) begin
        if (rows == 0) continue;
        break;
      end
      len = (line.size() > W) ? W : line.size();
      if (line.size() > W) err = 1'b1;
      for (int j = 0; j < line.size(); j++) begin
        if (line[j] != CH_PAPER && line[j] != CH_EMPTY) err = 1'b1;
        if (j < W && line[j] == CH_PAPER) begin
          g[rows*W + j] = 1'b1;
          papers++;
        end
      end
`ifdef GRID_LOADER_RAGGED_CHECK_EN
      if (first_len < 0) first_len = len;
      else if (len != first_len) err = 1'b1;
`endif
      rows++;
      line.delete();
      if (rows == D) break;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) chk("accept_timeout", GW'(bus.in_ready), GW'(1));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_frame(input bq_t q, input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(0, 7) == 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      if (i == q.size() - 1) chk("gv_before_last", GW'(bus.grid_valid), GW'(0));
      send_byte(q[i]);
    end
    bus.in_valid = 1'b0;
    chk("gv_rise", GW'(bus.grid_valid), GW'(1));
    chk("in_ready_hold", GW'(bus.in_ready), GW'(0));
  endtask

  task automatic check_model(input bq_t q);
    logic [GW-1:0] g;
    int rows, papers;
    logic err;
    model(q, g, rows, papers, err);
    chk("grid", bus.grid_out, g);
    chk("rows_loaded", GW'(bus.rows_loaded), GW'(rows));
    chk("paper_count", GW'(bus.paper_count), GW'(papers));
    chk("fmt_err", GW'(bus.fmt_err), GW'(err));
  endtask

  task automatic consume(input int delay, input bit push);
    logic [GW-1:0] saved_grid;
    logic [GW-1:0] saved_cnt;
    saved_grid = bus.grid_out;
    saved_cnt  = GW'(bus.paper_count);
    for (int i = 0; i < delay; i++) begin
      bus.in_valid = push ? 1'b1 : 1'($urandom_range(0, 1));
      bus.in_data  = CH_PAPER;
      @(negedge clk);
      chk("hold_in_ready", GW'(bus.in_ready), GW'(0));
      chk("hold_gv", GW'(bus.grid_valid), GW'(1));
      chk("hold_grid", bus.grid_out, saved_grid);
      chk("hold_count", GW'(bus.paper_count), saved_cnt);
    end
    bus.in_valid   = 1'b0;
    bus.grid_ready = 1'b1;
    @(negedge clk);
    bus.grid_ready = 1'b0;
    chk("rel_in_ready", GW'(bus.in_ready), GW'(1));
    chk("rel_gv", GW'(bus.grid_valid), GW'(0));
    chk("rel_grid", bus.grid_out, GW'(0));
    chk("rel_count", GW'(bus.paper_count), GW'(0));
    chk("rel_rows", GW'(bus.rows_loaded), GW'(0));
    chk("rel_err", GW'(bus.fmt_err), GW'(0));
  endtask

  function automatic logic [7:0] bad_byte();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255));
    while (b == CH_PAPER || b == CH_EMPTY || b == CH_LF || b == CH_CR);
    return b;
  endfunction

  function automatic bq_t gen_frame();
    bq_t q;
    int  rows, len_base, len, sel;
    rows     = $urandom_range(1, D);
    len_base = $urandom_range(1, W);
    if ($urandom_range(0, 3) == 0) q.push_back(CH_LF);
    for (int r = 0; r < rows; r++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W + 2) : len_base;
      for (int c = 0; c < len; c++) begin
        sel = $urandom_range(0, 39);
        if (sel == 0) q.push_back(CH_CR);
        if (sel == 1) q.push_back(bad_byte());
        else q.push_back(($urandom_range(0, 1) == 1) ? CH_PAPER : CH_EMPTY);
      end
      q.push_back(CH_LF);
    end
    if (rows < D) begin
      if ($urandom_range(0, 3) == 0) q.push_back(CH_CR);
      q.push_back(CH_LF);
    end
    return q;
  endfunction

  initial begin
    bq_t q;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.grid_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", GW'(bus.in_ready), GW'(1));
    chk("rst_gv", GW'(bus.grid_valid), GW'(0));
    chk("rst_grid", bus.grid_out, GW'(0));
    chk("rst_rows", GW'(bus.rows_loaded), GW'(0));
    chk("rst_count", GW'(bus.paper_count), GW'(0));
    chk("rst_err", GW'(bus.fmt_err), GW'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    q = str2q("@@.\n.@.\n@..\n\n");
    load_frame(q, 1'b0);
    chk("s3_row0", GW'(row_of(bus.grid_out, 0)), GW'(16'h0003));
    chk("s3_row1", GW'(row_of(bus.grid_out, 1)), GW'(16'h0002));
    chk("s3_row2", GW'(row_of(bus.grid_out, 2)), GW'(16'h0001));
    chk("s3_rows", GW'(bus.rows_loaded), GW'(3));
    chk("s3_count", GW'(bus.paper_count), GW'(4));
    chk("s3_err", GW'(bus.fmt_err), GW'(0));
    check_model(q);
    consume(0, 1'b0);

    q.delete();
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < W; c++) q.push_back(CH_PAPER);
      q.push_back(CH_LF);
    end
    load_frame(q, 1'b0);
    chk("full_count", GW'(bus.paper_count), GW'(256));
    chk("full_grid", bus.grid_out, '1);
    chk("full_rows", GW'(bus.rows_loaded), GW'(16));
    consume(10, 1'b1);

    q = str2q("@x@\n\n");
    load_frame(q, 1'b0);
    chk("bad_err", GW'(bus.fmt_err), GW'(1));
    chk("bad_row0", GW'(row_of(bus.grid_out, 0)), GW'(16'h0005));
    chk("bad_count", GW'(bus.paper_count), GW'(2));
    consume(1, 1'b0);

    q = str2q("@@@@@@@@@@@@@@@@@\n\n");
    load_frame(q, 1'b0);
    chk("long_row0", GW'(row_of(bus.grid_out, 0)), GW'(16'hFFFF));
    chk("long_count", GW'(bus.paper_count), GW'(16));
    chk("long_err", GW'(bus.fmt_err), GW'(1));
    consume(2, 1'b0);

    q = str2q("@@@.@");
    for (int i = 0; i < q.size(); i++) send_byte(q[i]);
    bus.in_valid = 1'b0;
    chk("pre_rst_count", GW'(bus.paper_count), GW'(4));
    #2 rst = 1'b1;
    #1;
    chk("arst_grid", bus.grid_out, GW'(0));
    chk("arst_count", GW'(bus.paper_count), GW'(0));
    chk("arst_in_ready", GW'(bus.in_ready), GW'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    q = str2q("@\n\n");
    load_frame(q, 1'b0);
    chk("post_rst_row0", GW'(row_of(bus.grid_out, 0)), GW'(16'h0001));
    chk("post_rst_count", GW'(bus.paper_count), GW'(1));
    consume(0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      q = gen_frame();
      load_frame(q, 1'b1);
      check_model(q);
      consume($urandom_range(0, 4), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grid_loader.md
Name: grid_loader

Overview:
- Upstream stage of the removal datapath (`remove_accessible` sweep and iterative-removal controller).
- Accepts the puzzle grid as an ASCII byte stream over a valid/ready handshake and assembles it into a WIDTH x DEPTH occupancy bitmap (1 = paper '@', 0 = empty '.').
- Holds the completed bitmap on a valid/ready output handshake until the consumer takes it, then loads the next frame.

Parameters:
- WIDTH, 16, columns per grid row (bits per row).
- DEPTH, 16, rows per grid.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a byte.
- in_ready  output  1  loader accepts a byte this cycle.
- in_data  input  8  ASCII byte.
- grid_valid  output  1  grid_out/metadata hold a complete frame.
- grid_ready  input  1  consumer takes the frame.
- grid_out  output  WIDTH*DEPTH  bitmap; row i = bits [i*WIDTH +: WIDTH], column j = bit i*WIDTH+j.
- rows_loaded  output  $clog2(DEPTH+1)  number of non-blank rows in the frame.
- paper_count  output  $clog2(WIDTH*DEPTH+1)  number of '@' in the frame.
- fmt_err  output  1  frame contained an illegal byte or an over-long row.

Behaviour:
- Clock/reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: state = LOAD, in_ready = 1, grid_valid = 0, grid_out = 0, rows_loaded = 0, paper_count = 0, fmt_err = 0, col = 0, row = 0.
- Byte accept: in_valid && in_ready.
- States:
  - LOAD: in_ready = 1, grid_valid = 0.
  - HOLD: in_ready = 0, grid_valid = 1; all outputs stable.
- Byte decode in LOAD:
  - '@' (0x40): set bit [row][col], col++, paper_count++.
  - '.' (0x2E): bit stays 0, col++.
  - '\r' (0x0D): ignored; col unchanged.
  - '\n' (0x0A) with col > 0: row complete; columns >= col stay 0 (short rows are zero-padded); row++, col = 0.
  - '\n' with col == 0 and row == 0: leading blank line, ignored.
  - '\n' with col == 0 and row > 0: end of frame.
  - Any other byte: fmt_err = 1; treated as '.' (col++).
- Over-long row: a '@' or '.' arriving with col == WIDTH sets fmt_err = 1; the byte is dropped, col saturates at WIDTH and paper_count is unchanged.
- LOAD -> HOLD:
  - On the cycle after the terminating '\n' is accepted: either a blank line (row > 0), or the '\n' that completes row DEPTH-1 (row reaches DEPTH).
  - grid_valid rises exactly 1 cycle after that accept.
  - rows_loaded = row at the transition.
- HOLD -> LOAD:
  - On grid_valid && grid_ready; in_ready returns the next cycle.
  - grid_out, counters and fmt_err clear on that same edge.
  - grid_valid may be high with grid_ready already high, giving a 1-cycle hold.
- Back-to-back frames: maximum input throughput is 1 byte/cycle; there is one dead input cycle per frame (HOLD).
- rst mid-frame or mid-HOLD discards the partial/held frame immediately (asynchronous); the loader restarts in LOAD.
- Arithmetic: col is $clog2(WIDTH+1) bits and saturates; row is $clog2(DEPTH+1) bits. paper_count cannot overflow by construction, because dropped bytes are not counted.

Optional Feature:
- Macro: GRID_LOADER_RAGGED_CHECK_EN.
- Defined:
  - The loader latches the length of the first row.
  - Any later row whose '\n' arrives with col differing from that length sets fmt_err.
  - The row is still stored (zero-padded or truncated per the normal rules).
- Undefined: rows of unequal length are accepted silently; fmt_err reflects only illegal bytes and over-long rows.

Decomposition:
- Shared package grid_pkg:
  - default WIDTH/DEPTH;
  - ASCII constants CH_PAPER = 8'h40, CH_EMPTY = 8'h2E, CH_LF = 8'h0A, CH_CR = 8'h0D;
  - state enum {LOAD, HOLD};
  - width helper functions for the col/row/count widths.
- The byte classifier (byte -> is_paper, is_empty, is_lf, is_cr, is_bad) is a natural combinational sub-module, grid_char_decode.
- The FSM, bitmap write and counters stay in grid_loader.

Test Plan:
- 3x3 frame "@@.\n.@.\n@..\n\n" (WIDTH = DEPTH = 16):
  - grid_valid rises 1 cycle after the final '\n'.
  - Row 0 = 0x0003, row 1 = 0x0002, row 2 = 0x0001.
  - rows_loaded = 3, paper_count = 4, fmt_err = 0.
- Full 16x16 all-'@' frame with no trailing blank line: HOLD entered after the 16th '\n'; paper_count = 256; grid_out all ones.
- Row "@x@\n" then "\n": fmt_err = 1; row 0 = 0x0005; paper_count = 2.
- 17-char row of '@' in a WIDTH = 16 frame: row 0 = 0xFFFF, paper_count = 16, fmt_err = 1.
- Backpressure: hold grid_ready = 0 for 10 cycles with in_valid = 1. Required: in_ready = 0 throughout and outputs stable; on the grid_ready pulse, the next cycle has in_ready = 1 and all counters = 0.
- Assert rst asynchronously after 5 bytes of a frame: outputs are 0 immediately. Then a clean "@\n\n" gives row 0 = 0x0001, paper_count = 1.
